// File: rtl/mc_des_fifo.sv
// Serial deserializer feeding a small word queue, both paced by tick enables
// derived from the single 1 MHz clock. Completed words wait in a hold register
// (status_out low) until a queue tick either enqueues them, drops them (when
// the queue is full and DROP_ON_FULL is set), or leaves them pending.
//
// Handshake: the deserializer raises "pending" (state WAIT_ACK) with the word in
// hold_reg; the queue side consumes it only on a q_tick by returning a
// one-cycle ack, and the word stays valid and unchanged until that ack.
// status_out is a direct decode of the deserializer state (1 = RECV).
module mc_des_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 8,
    parameter int DES_DIV      = 10,
    parameter int Q_DIV        = 100,
    parameter int MSB_FIRST    = 1,
    parameter int DROP_ON_FULL = 0
) (
    input  logic                     clock_1MHz,
    input  logic                     reset,
    input  logic                     data_in,
    input  logic                     write_in,
    input  logic                     dequeue_in,
    input  logic                     clear_ovf,
    output logic                     status_out,
    output logic [$clog2(DEPTH):0]   len_out,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int DCW = (DES_DIV > 1) ? $clog2(DES_DIV) : 1;
    localparam int QCW = (Q_DIV > 1) ? $clog2(Q_DIV) : 1;
    localparam int BCW = $clog2(DATA_W + 1);

    typedef enum logic {
        RECV     = 1'b0,
        WAIT_ACK = 1'b1
    } des_state_t;

    logic [DCW-1:0]    des_cnt;
    logic [QCW-1:0]    q_cnt;
    logic              des_tick;
    logic              q_tick;

    des_state_t        state;
    des_state_t        state_next;
    logic [BCW-1:0]    bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] hold_reg;
    logic              capture;
    logic              word_done;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pending;
    logic              do_deq;
    logic              do_enq;
    logic              do_drop;
    logic              ack;

    assign des_tick = (des_cnt == DCW'(DES_DIV - 1));
    assign q_tick   = (q_cnt == QCW'(Q_DIV - 1));

    // Free-running tick dividers, wrapping after the terminal count.
    always_ff @(posedge clock_1MHz or posedge reset) begin
        if (reset) begin
            des_cnt <= '0;
            q_cnt   <= '0;
        end else begin
            des_cnt <= des_tick ? '0 : des_cnt + 1'b1;
            q_cnt   <= q_tick ? '0 : q_cnt + 1'b1;
        end
    end

    // Deserializer state register.
    always_ff @(posedge clock_1MHz or posedge reset) begin
        if (reset) state <= RECV;
        else       state <= state_next;
    end

    // Next-state logic plus the shifted word the current bit would produce.
    always_comb begin
        state_next = state;
        if (MSB_FIRST != 0) shift_next = {shift_reg[DATA_W-2:0], data_in};
        else                shift_next = {data_in, shift_reg[DATA_W-1:1]};
        capture   = (state == RECV) && des_tick && write_in;
        word_done = capture && (bit_cnt == BCW'(DATA_W - 1));
        case (state)
            RECV:     if (word_done) state_next = WAIT_ACK;
            WAIT_ACK: if (ack)       state_next = RECV;
            default:  state_next = RECV;
        endcase
    end

    // Shift register, bit counter and hold register of the deserializer.
    always_ff @(posedge clock_1MHz or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            hold_reg  <= '0;
        end else if (capture) begin
            shift_reg <= shift_next;
            if (word_done) begin
                hold_reg <= shift_next;
                bit_cnt  <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign status_out = (state == RECV);
    assign pending    = (state == WAIT_ACK);
    assign full       = (len_out == (AW + 1)'(DEPTH));
    assign empty      = (len_out == '0);

    // A full queue still accepts the pending word when a dequeue frees a slot
    // on the same tick; an empty queue never bypasses the word to data_out.
    assign do_deq  = q_tick && dequeue_in && !empty;
    assign do_enq  = q_tick && pending && (!full || do_deq);
    assign do_drop = q_tick && pending && full && !do_deq && (DROP_ON_FULL != 0);
    assign ack     = do_enq || do_drop;

    // Queue storage; contents need no reset because len_out guards every read.
    always_ff @(posedge clock_1MHz) begin
        if (do_enq) mem[wr_ptr] <= hold_reg;
    end

    // Pointers, occupancy, output word, valid pulse and sticky overflow.
    always_ff @(posedge clock_1MHz or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            len_out    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            data_valid <= do_deq;
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            if (do_enq && !do_deq)      len_out <= len_out + 1'b1;
            else if (do_deq && !do_enq) len_out <= len_out - 1'b1;
            if (do_drop)        overflow <= 1'b1;
            else if (clear_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_des_fifo.sv
// Bench for mc_des_fifo: three instances (hold-on-full, drop-on-full, and a
// small LSB-first fast-tick variant) share one stimulus stream. A cycle-level
// behavioural model of each instance is compared against every output on each
// cycle, and directed scenarios pin the model with literal expectations.
module tb_mc_des_fifo;

    logic clk;
    logic rst;
    logic data_in;
    logic write_in;
    logic dequeue_in;
    logic clear_ovf;

    logic       st0, dv0, fu0, em0, ov0;
    logic [3:0] len0;
    logic [7:0] do0;
    logic       st1, dv1, fu1, em1, ov1;
    logic [3:0] len1;
    logic [7:0] do1;
    logic       st2, dv2, fu2, em2, ov2;
    logic [2:0] len2;
    logic [7:0] do2;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    // Per-instance model parameters: u0, u1, u2.
    localparam int M_DES[3]   = '{10, 10, 3};
    localparam int M_Q[3]     = '{100, 100, 7};
    localparam int M_DEPTH[3] = '{8, 8, 4};
    localparam int M_MSB[3]   = '{1, 1, 0};
    localparam int M_DROP[3]  = '{0, 1, 0};

    // Behavioural model state.
    logic [7:0] exp_q [3][$];
    int         m_cyc  [3];
    int         m_nb   [3];
    logic [7:0] m_w    [3];
    logic [7:0] m_pw   [3];
    bit         m_pend [3];
    logic [7:0] m_dout [3];
    bit         m_dv   [3];
    bit         m_ovf  [3];

    logic [7:0] rx0 [$];
    logic [7:0] rx1 [$];

    mc_des_fifo #(.DATA_W(8), .DEPTH(8), .DES_DIV(10), .Q_DIV(100),
                  .MSB_FIRST(1), .DROP_ON_FULL(0)) u0 (
        .clock_1MHz(clk), .reset(rst), .data_in(data_in), .write_in(write_in),
        .dequeue_in(dequeue_in), .clear_ovf(clear_ovf), .status_out(st0),
        .len_out(len0), .data_out(do0), .data_valid(dv0), .full(fu0),
        .empty(em0), .overflow(ov0));

    mc_des_fifo #(.DATA_W(8), .DEPTH(8), .DES_DIV(10), .Q_DIV(100),
                  .MSB_FIRST(1), .DROP_ON_FULL(1)) u1 (
        .clock_1MHz(clk), .reset(rst), .data_in(data_in), .write_in(write_in),
        .dequeue_in(dequeue_in), .clear_ovf(clear_ovf), .status_out(st1),
        .len_out(len1), .data_out(do1), .data_valid(dv1), .full(fu1),
        .empty(em1), .overflow(ov1));

    mc_des_fifo #(.DATA_W(8), .DEPTH(4), .DES_DIV(3), .Q_DIV(7),
                  .MSB_FIRST(0), .DROP_ON_FULL(0)) u2 (
        .clock_1MHz(clk), .reset(rst), .data_in(data_in), .write_in(write_in),
        .dequeue_in(dequeue_in), .clear_ovf(clear_ovf), .status_out(st2),
        .len_out(len2), .data_out(do2), .data_valid(dv2), .full(fu2),
        .empty(em2), .overflow(ov2));

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(bit st, int len, logic [7:0] d, bit dv,
                                         bit fu, bit em, bit ov);
        logic [3:0] l4;
        l4 = len[3:0];
        return {15'd0, st, l4, d, dv, fu, em, ov};
    endfunction

    // Model reset.
    task automatic model_reset(input int i);
        exp_q[i].delete();
        m_cyc[i]  = 0;
        m_nb[i]   = 0;
        m_w[i]    = 8'h00;
        m_pw[i]   = 8'h00;
        m_pend[i] = 0;
        m_dout[i] = 8'h00;
        m_dv[i]   = 0;
        m_ovf[i]  = 0;
    endtask

    // One clock of instance i: ticks from elapsed cycle count, queue rules,
    // then word assembly by bit position.
    task automatic model_step(input int i);
        bit dt, qt, deq, was_full, ack;
        int sz;
        dt = (m_cyc[i] % M_DES[i]) == (M_DES[i] - 1);
        qt = (m_cyc[i] % M_Q[i]) == (M_Q[i] - 1);
        m_cyc[i]++;
        ack     = 0;
        m_dv[i] = 0;
        if (clear_ovf) m_ovf[i] = 0;
        if (qt) begin
            sz       = exp_q[i].size();
            was_full = (sz == M_DEPTH[i]);
            deq      = dequeue_in && (sz > 0);
            if (deq) begin
                m_dout[i] = exp_q[i].pop_front();
                m_dv[i]   = 1;
            end
            if (m_pend[i]) begin
                if (!was_full || deq) begin
                    exp_q[i].push_back(m_pw[i]);
                    ack = 1;
                end else if (M_DROP[i] != 0) begin
                    m_ovf[i] = 1;
                    ack      = 1;
                end
            end
        end
        if (m_pend[i]) begin
            if (ack) m_pend[i] = 0;
        end else if (dt && write_in) begin
            if (m_nb[i] == 0) m_w[i] = 8'h00;
            m_w[i][(M_MSB[i] != 0) ? 7 - m_nb[i] : m_nb[i]] = data_in;
            m_nb[i]++;
            if (m_nb[i] == 8) begin
                m_pw[i]   = m_w[i];
                m_pend[i] = 1;
                m_nb[i]   = 0;
            end
        end
    endtask

    // Model advance on every clock edge; follows the asynchronous reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) model_reset(i);
        end else begin
            for (int i = 0; i < 3; i++) model_step(i);
        end
    end

    // Compare process: all outputs of all instances on every falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                logic [31:0] act, exp;
                int sz;
                sz  = exp_q[i].size();
                exp = pack(!m_pend[i], sz, m_dout[i], m_dv[i],
                           sz == M_DEPTH[i], sz == 0, m_ovf[i]);
                case (i)
                    0:       act = pack(st0, int'(len0), do0, dv0, fu0, em0, ov0);
                    1:       act = pack(st1, int'(len1), do1, dv1, fu1, em1, ov1);
                    default: act = pack(st2, int'(len2), do2, dv2, fu2, em2, ov2);
                endcase
                check($sformatf("u%0d outputs", i), act, exp);
            end
            if (dv0) rx0.push_back(do0);
            if (dv1) rx1.push_back(do1);
        end
    end

    // Driver tasks.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        int n = 0;
        while (!st0 && n < 400) begin
            tick(1);
            n++;
        end
        check("send wait status", 32'(st0), 32'd1);
        for (int b = 7; b >= 0; b--) begin
            data_in  = w[b];
            write_in = 1'b1;
            tick(10);
        end
        write_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic wait_len0(input int target, input int bound, input string name);
        int n = 0;
        while (int'(len0) != target && n < bound) begin
            tick(1);
            n++;
        end
        check(name, 32'(len0), 32'(target));
    endtask

    task automatic wait_dv0(input int bound, input string name);
        int n = 0;
        while (!dv0 && n < bound) begin
            tick(1);
            n++;
        end
        check(name, 32'(dv0), 32'd1);
    endtask

    task automatic dequeue_one(input string name);
        dequeue_in = 1'b1;
        wait_dv0(110, name);
        dequeue_in = 1'b0;
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        rst        = 1'b1;
        data_in    = 1'b0;
        write_in   = 1'b0;
        dequeue_in = 1'b0;
        clear_ovf  = 1'b0;
        tick(3);
        check("reset u0", pack(st0, int'(len0), do0, dv0, fu0, em0, ov0),
              pack(1, 0, 8'h00, 0, 0, 1, 0));
        check("reset u1", pack(st1, int'(len1), do1, dv1, fu1, em1, ov1),
              pack(1, 0, 8'h00, 0, 0, 1, 0));
        started = 1;
        rst     = 1'b0;

        // Single word 0xA5 MSB first, then dequeue.
        send_word(8'hA5);
        wait_len0(1, 110, "A5 enqueued");
        dequeue_one("A5 dequeue pulse");
        check("A5 data_out", 32'(do0), 32'h000000A5);
        check("A5 len after", 32'(len0), 32'd0);
        tick(1);
        check("A5 pulse one cycle", 32'(dv0), 32'd0);

        // Dequeue requests on an empty queue.
        dequeue_in = 1'b1;
        tick(250);
        dequeue_in = 1'b0;
        check("empty deq data held", 32'(do0), 32'h000000A5);
        check("empty deq len", 32'(len0), 32'd0);

        // Fill both queues, then send a ninth word.
        for (int w = 1; w <= 8; w++) send_word(8'(w));
        wait_len0(8, 250, "fill len");
        check("fill full u0", 32'(fu0), 32'd1);
        check("fill full u1", 32'(fu1), 32'd1);
        send_word(8'h09);
        tick(250);
        check("held word status u0", 32'(st0), 32'd0);
        check("dropped word status u1", 32'(st1), 32'd1);
        check("overflow u1", 32'(ov1), 32'd1);
        check("no overflow u0", 32'(ov0), 32'd0);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        check("overflow cleared u1", 32'(ov1), 32'd0);

        // Drain; the first dequeue coincides with the held word's enqueue.
        rx0.delete();
        rx1.delete();
        for (int k = 0; k < 9; k++) begin
            dequeue_one("drain pulse");
            if (k == 0) begin
                check("simul enq/deq len", 32'(len0), 32'd8);
                check("simul enq/deq ovf", 32'(ov0), 32'd0);
            end
            tick(1);
        end
        tick(5);
        check("drain count u0", 32'(rx0.size()), 32'd9);
        check("drain count u1", 32'(rx1.size()), 32'd8);
        for (int k = 0; k < rx0.size(); k++)
            check($sformatf("drain u0 word %0d", k), 32'(rx0[k]), 32'(k + 1));
        for (int k = 0; k < rx1.size(); k++)
            check($sformatf("drain u1 word %0d", k), 32'(rx1[k]), 32'(k + 1));

        // Reset in the middle of a word.
        for (int b = 0; b < 4; b++) begin
            data_in  = b[0];
            write_in = 1'b1;
            tick(10);
        end
        write_in = 1'b0;
        rst      = 1'b1;
        tick(2);
        check("mid-word reset status", 32'(st0), 32'd1);
        check("mid-word reset len", 32'(len0), 32'd0);
        rst = 1'b0;
        tick(1);
        send_word(8'h3C);
        wait_len0(1, 110, "3C enqueued");
        dequeue_one("3C dequeue pulse");
        check("3C data_out", 32'(do0), 32'h0000003C);

        // Randomized traffic with one asynchronous reset partway through.
        for (int c = 0; c < 15000; c++) begin
            data_in    = 1'($urandom_range(0, 1));
            write_in   = ($urandom_range(0, 3) != 0);
            dequeue_in = ($urandom_range(0, 5) == 0);
            clear_ovf  = ($urandom_range(0, 40) == 0);
            if (c == 7000) begin
                #1;
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            tick(1);
        end
        write_in   = 1'b0;
        dequeue_in = 1'b0;
        clear_ovf  = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_des_fifo.md
MC_DES_FIFO -- requirements
Module: mc_des_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: serial word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: queue entries; power of two, at least 2.
REQ-003 SHALL have parameter DES_DIV, default 10: clock_1MHz cycles per deserializer tick (100 kHz rate).
REQ-004 SHALL have parameter Q_DIV, default 100: clock_1MHz cycles per queue tick (10 kHz rate).
REQ-005 SHALL have parameter MSB_FIRST, default 1: 1 means the first received bit lands in the word MSB; 0 means it lands in the LSB.
REQ-006 SHALL have parameter DROP_ON_FULL, default 0: 1 means a completed word is discarded when the queue is full; 0 means it is held until space frees.
REQ-007 SHALL have port clock_1MHz  in  1  sole clock.
REQ-008 SHALL have port reset  in  1  asynchronous, active-high.
REQ-009 SHALL have port data_in  in  1  serial data bit.
REQ-010 SHALL have port write_in  in  1  bit qualifier; the bit is shifted only when this is high.
REQ-011 SHALL have port dequeue_in  in  1  dequeue request.
REQ-012 SHALL have port clear_ovf  in  1  clears overflow.
REQ-013 SHALL have port status_out  out  1  1 = deserializer accepting bits.
REQ-014 SHALL have port len_out  out  $clog2(DEPTH)+1  queue occupancy.
REQ-015 SHALL have port data_out  out  DATA_W  last dequeued word.
REQ-016 SHALL have port data_valid  out  1  one-cycle pulse per successful dequeue.
REQ-017 SHALL have ports full and empty  out  1 each.
REQ-018 SHALL have port overflow  out  1  sticky word-dropped flag.

Function
REQ-019 SHALL run all logic on clock_1MHz and use one-cycle tick enables; there SHALL be no derived clocks.
REQ-020 des_tick SHALL pulse for one cycle when its counter (0..DES_DIV-1) equals DES_DIV-1, then wrap; q_tick SHALL behave identically with Q_DIV.
REQ-021 The deserializer FSM SHALL have exactly two states: RECV (status_out=1) and WAIT_ACK (status_out=0).
REQ-022 In RECV, on des_tick with write_in=1, the FSM SHALL shift data_in per MSB_FIRST and increment the bit count; with write_in=0 it SHALL do nothing.
REQ-023 When the bit count reaches DATA_W, the FSM SHALL latch the word into a hold register, zero the count, and enter WAIT_ACK.
REQ-024 In WAIT_ACK, the FSM SHALL ignore data_in and write_in; an internal one-cycle ack SHALL return it to RECV on the next cycle.
REQ-025 On q_tick with a pending word and the queue not full, the block SHALL enqueue the word and issue ack.
REQ-026 On q_tick with a pending word, the queue full, and DROP_ON_FULL=1, the block SHALL discard the word, set overflow, and issue ack.
REQ-027 On q_tick with a pending word, the queue full, and DROP_ON_FULL=0, the block SHALL issue no ack and hold the word for a later q_tick.
REQ-028 On q_tick with dequeue_in=1 and the queue not empty, the block SHALL register the head entry to data_out, pulse data_valid, and decrement len.
REQ-029 A dequeue on an empty queue SHALL be a no-op: data_valid=0, data_out held.
REQ-030 Simultaneous enqueue and dequeue on the same q_tick while full SHALL perform both, leave len unchanged, and not set overflow.
REQ-031 Simultaneous enqueue and dequeue on the same q_tick while empty SHALL perform the enqueue only; there SHALL be no bypass.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH.
REQ-033 full SHALL equal (len==DEPTH) and empty SHALL equal (len==0), both decoded combinationally from registered len.
REQ-034 overflow SHALL clear on clear_ovf=1; if set and clear occur in the same cycle, set SHALL win.
REQ-035 Latency from word completion to enqueue SHALL be at most Q_DIV cycles, with len_out updated on the q_tick edge.

Reset
REQ-036 On reset the block SHALL drive status_out=1, len_out=0, data_out=0, data_valid=0, full=0, empty=1, overflow=0.
REQ-037 On reset the block SHALL zero all tick counters, bit count, shift and hold registers, and pointers, and SHALL set the FSM to RECV.
REQ-038 Reset mid-word SHALL discard the partial word, and reset SHALL discard any pending held word.

Verification
REQ-039 Bits 1,0,1,0,0,1,0,1 with write_in=1 on each des_tick -> len_out=1 within 100 cycles; then dequeue_in -> data_out=0xA5, one data_valid pulse, len_out=0.
REQ-040 Enqueue words 0x01..0x08 -> full=1, len_out=8; send 0x09 with DROP_ON_FULL=0 -> status_out stays 0; dequeue 0x01 -> 0x09 enqueued; later dequeues return 0x02..0x09 in order.
REQ-041 Same as REQ-040 with DROP_ON_FULL=1 -> overflow=1, 0x09 lost, status_out returns to 1; clear_ovf -> overflow=0.
REQ-042 dequeue_in on empty queue -> data_valid=0, len_out=0, data_out unchanged.
REQ-043 Reset after 4 bits -> status_out=1, len_out=0; a subsequent full word 0x3C is received and enqueued intact.
REQ-044 Full queue with a word pending and dequeue_in on the same q_tick -> len_out stays 8, overflow=0, FIFO order preserved.
